// File: rtl/dec_pkg.sv
// Shared types and constants for the decryption select controller.
// The state encoding, the legal select values and the default end-of-message byte are defined here.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] SEL_0       = 2'd0;
    localparam logic [1:0] SEL_1       = 2'd1;
    localparam logic [1:0] SEL_2       = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    localparam logic [7:0] END_TOKEN_DEFAULT = 8'hFA;

    // Busy flag of the currently selected decryptor; an illegal select reads as idle.
    function automatic logic sel_busy(input logic [2:0] busy, input logic [1:0] sel);
        case (sel)
            SEL_0:   return busy[0];
            SEL_1:   return busy[1];
            SEL_2:   return busy[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dec_drain_monitor.sv
// Counts consecutive quiet cycles and total cycles while the controller drains a message.
// Both flags are combinational, so the controller acts on the same edge the threshold is reached.
module dec_drain_monitor
    import dec_pkg::*;
#(
    parameter int QUIET_CYC = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic quiet_i,
    output logic drain_ok_o,
    output logic drain_timeout_o
);

    logic [3:0] quiet_q, quiet_d;
    logic [7:0] cyc_q, cyc_d;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        quiet_d = '0;
        cyc_d   = '0;
        if (en_i) begin
            cyc_d   = cyc_q + 8'd1;
            quiet_d = quiet_i ? quiet_q + 4'd1 : 4'd0;
        end
    end

    // NOTE: reset is synchronous and active-low; sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quiet_q <= '0;
            cyc_q   <= '0;
        end else begin
            quiet_q <= quiet_d;
            cyc_q   <= cyc_d;
        end
    end

    assign drain_ok_o      = en_i && quiet_i && (quiet_q == 4'(QUIET_CYC - 1));
    assign drain_timeout_o = en_i && (cyc_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dec_select_ctrl.sv
// Sequencing controller: owns the decryptor select, gates one message at a time into the
// datapath and only switches select after the active decryptor has drained.
module dec_select_ctrl
    import dec_pkg::*;
#(
    parameter int                   D_WIDTH   = 8,
    parameter logic [D_WIDTH-1:0]   END_TOKEN = D_WIDTH'(END_TOKEN_DEFAULT),
    parameter int                   QUIET_CYC = 4,
    parameter int                   TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         sel_req_i,
    input  logic               sel_req_valid_i,
    output logic               sel_req_ready_o,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [D_WIDTH-1:0] dec_data_o,
    output logic               dec_valid_o,
    output logic [1:0]         select_o,
    input  logic [2:0]         busy_i,
    input  logic               out_valid_i,
    output logic               done_o,
    output logic               err_o
);

    state_t             state_q, state_d;
    logic [1:0]         select_q, select_d;
    logic               slot_valid_q, slot_valid_d;
    logic [1:0]         slot_sel_q, slot_sel_d;
    logic [D_WIDTH-1:0] dec_data_q, dec_data_d;
    logic               dec_valid_q, dec_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic consume, req_illegal, req_accept, byte_acc;
    logic drain_ok, drain_timeout;

    assign ready_o     = (state_q == RUN);
    assign byte_acc    = valid_i && ready_o;
    assign consume     = (state_q == IDLE) && slot_valid_q;
    assign req_illegal = sel_req_valid_i && (sel_req_i == SEL_ILLEGAL);
    // The slot may be refilled on the very cycle IDLE consumes it.
    assign req_accept  = sel_req_valid_i && !req_illegal && (!slot_valid_q || consume);

    dec_drain_monitor #(
        .QUIET_CYC (QUIET_CYC),
        .TIMEOUT   (TIMEOUT)
    ) u_drain_monitor (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_i            (state_q == DRAIN),
        .quiet_i         (!sel_busy(busy_i, select_q) && !out_valid_i),
        .drain_ok_o      (drain_ok),
        .drain_timeout_o (drain_timeout)
    );

    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        slot_valid_d = slot_valid_q;
        slot_sel_d   = slot_sel_q;
        dec_data_d   = dec_data_q;
        dec_valid_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = req_illegal;

        case (state_q)
            IDLE: begin
                if (slot_valid_q) begin
                    select_d = slot_sel_q;
                    state_d  = ARM;
                end
            end
            ARM: state_d = RUN;
            RUN: begin
                if (byte_acc) begin
                    dec_data_d  = data_i;
                    dec_valid_d = 1'b1;
                    if (data_i == END_TOKEN) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Timeout takes priority over a simultaneous clean drain.
                if (drain_timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (drain_ok) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume) slot_valid_d = 1'b0;
        if (req_accept) begin
            slot_valid_d = 1'b1;
            slot_sel_d   = sel_req_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            select_q     <= SEL_0;
            slot_valid_q <= 1'b0;
            slot_sel_q   <= SEL_0;
            dec_data_q   <= '0;
            dec_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            slot_valid_q <= slot_valid_d;
            slot_sel_q   <= slot_sel_d;
            dec_data_q   <= dec_data_d;
            dec_valid_q  <= dec_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign sel_req_ready_o = !slot_valid_q;
    assign dec_data_o      = dec_data_q;
    assign dec_valid_o     = dec_valid_q;
    assign select_o        = select_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_dec_select_ctrl.sv
// Self-checking bench for dec_select_ctrl: forwarded bytes are scoreboarded, control timing
// (select switch, drain completion, timeout, illegal request, reset) is checked directly.
module tb_dec_select_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel_req_i;
    logic       sel_req_valid_i;
    logic       sel_req_ready_o;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] dec_data_o;
    logic       dec_valid_o;
    logic [1:0] select_o;
    logic [2:0] busy_i;
    logic       out_valid_i;
    logic       done_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    dec_select_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sel_req_i       (sel_req_i),
        .sel_req_valid_i (sel_req_valid_i),
        .sel_req_ready_o (sel_req_ready_o),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .dec_data_o      (dec_data_o),
        .dec_valid_o     (dec_valid_o),
        .select_o        (select_o),
        .busy_i          (busy_i),
        .out_valid_i     (out_valid_i),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every forwarded byte must match the oldest byte the bench sent.
    always @(negedge clk) begin
        if (dec_valid_o === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_byte", 32'(dec_data_o), 32'hFFFF_FFFF);
            else                   check("sb_data", 32'(dec_data_o), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a select and advance until the controller is in RUN.
    task automatic start_msg(input logic [1:0] sel, input string tag);
        sel_req_i       = sel;
        sel_req_valid_i = 1'b1;
        tick();
        sel_req_valid_i = 1'b0;
        tick();
        check({tag, "_select"}, 32'(select_o), 32'(sel));
        check({tag, "_arm_ready"}, 32'(ready_o), 0);
        tick();
        check({tag, "_run_ready"}, 32'(ready_o), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_out);
        data_i  = b;
        valid_i = 1'b1;
        if (expect_out) exp_q.push_back(b);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int k);
        k = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (done_o) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int errs;
        int dones;
        bit flag;

        rst_n = 1'b0; sel_req_i = 2'd0; sel_req_valid_i = 1'b0;
        data_i = 8'h00; valid_i = 1'b0; busy_i = 3'b000; out_valid_i = 1'b0;
        tick(); tick();
        check("rst_sel_req_ready", 32'(sel_req_ready_o), 1);
        check("rst_ready", 32'(ready_o), 0);
        check("rst_select", 32'(select_o), 0);
        check("rst_dec_valid", 32'(dec_valid_o), 0);
        check("rst_dec_data", 32'(dec_data_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst_n = 1'b1;

        // 1: sel=1, three bytes back to back; non-selected busy bits are ignored.
        busy_i = 3'b101;
        sel_req_i = 2'd1; sel_req_valid_i = 1'b1;
        tick();
        sel_req_valid_i = 1'b0;
        check("t1_slot_full", 32'(sel_req_ready_o), 0);
        check("t1_select_early", 32'(select_o), 0);
        tick();
        check("t1_select", 32'(select_o), 1);
        check("t1_slot_empty", 32'(sel_req_ready_o), 1);
        check("t1_arm_ready", 32'(ready_o), 0);
        tick();
        check("t1_run_ready", 32'(ready_o), 1);
        send_byte(8'h41, 1'b1);
        check("t1_valid_41", 32'(dec_valid_o), 1);
        send_byte(8'h42, 1'b1);
        check("t1_valid_42", 32'(dec_valid_o), 1);
        send_byte(8'hFA, 1'b1);
        check("t1_valid_fa", 32'(dec_valid_o), 1);
        check("t1_drain_ready", 32'(ready_o), 0);
        wait_done(20, k);
        check("t1_done_latency", 32'(k), 4);
        tick();
        check("t1_done_pulse", 32'(done_o), 0);
        busy_i = 3'b000;

        // 2: sel=2 requested while a sel=0 message runs; switch only after done.
        start_msg(2'd0, "t2a");
        sel_req_i = 2'd2; sel_req_valid_i = 1'b1;
        send_byte(8'h10, 1'b1);
        sel_req_valid_i = 1'b0;
        check("t2_slot_full", 32'(sel_req_ready_o), 0);
        check("t2_select_hold_run", 32'(select_o), 0);
        send_byte(8'hFA, 1'b1);
        flag = 1'b0;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (select_o !== 2'd0) flag = 1'b1;
            if (done_o) begin
                k = i;
                break;
            end
        end
        check("t2_select_hold_drain", 32'(flag), 0);
        check("t2_done_latency", 32'(k), 4);
        tick();
        check("t2_select_switch", 32'(select_o), 2);
        check("t2_arm_ready", 32'(ready_o), 0);
        tick();
        check("t2_run_ready", 32'(ready_o), 1);
        send_byte(8'hFA, 1'b1);
        wait_done(20, k);
        check("t2b_done_latency", 32'(k), 4);

        // 3: illegal request.
        sel_req_i = 2'd3; sel_req_valid_i = 1'b1;
        tick();
        sel_req_valid_i = 1'b0;
        check("t3_err", 32'(err_o), 1);
        check("t3_slot_ready", 32'(sel_req_ready_o), 1);
        check("t3_select", 32'(select_o), 2);
        tick();
        check("t3_err_pulse", 32'(err_o), 0);
        tick(); tick();
        check("t3_no_arm", 32'(ready_o), 0);
        check("t3_select_hold", 32'(select_o), 2);

        // 4: selected decryptor stays busy, drain times out.
        busy_i = 3'b010;
        start_msg(2'd1, "t4");
        send_byte(8'hFA, 1'b1);
        k = -1; errs = 0; dones = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (err_o) begin
                errs++;
                if (k < 0) k = i;
            end
            if (done_o) dones++;
        end
        busy_i = 3'b000;
        check("t4_timeout_cycle", 32'(k), 255);
        check("t4_err_count", 32'(errs), 1);
        check("t4_no_done", 32'(dones), 0);
        check("t4_idle_ready", 32'(ready_o), 0);
        check("t4_select_hold", 32'(select_o), 1);

        // 5: out_valid_i pulses restart the quiet counter; busy on other decryptors is ignored.
        busy_i = 3'b110;
        start_msg(2'd0, "t5");
        send_byte(8'hFA, 1'b1);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            out_valid_i = (i <= 20) && (i % 3 == 0);
            tick();
            if (done_o) begin
                k = i;
                break;
            end
        end
        out_valid_i = 1'b0;
        busy_i = 3'b000;
        check("t5_done_cycle", 32'(k), 22);

        // 6: synchronous reset mid-message drops the in-flight byte.
        start_msg(2'd1, "t6a");
        send_byte(8'h33, 1'b1);
        data_i = 8'h55; valid_i = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; valid_i = 1'b0;
        check("t6_select", 32'(select_o), 0);
        check("t6_ready", 32'(ready_o), 0);
        check("t6_dec_valid", 32'(dec_valid_o), 0);
        check("t6_dec_data", 32'(dec_data_o), 0);
        check("t6_slot_ready", 32'(sel_req_ready_o), 1);
        check("t6_done", 32'(done_o), 0);
        check("t6_err", 32'(err_o), 0);
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dec_valid_o !== 1'b0 || ready_o !== 1'b0) flag = 1'b1;
        end
        check("t6_quiet_after_reset", 32'(flag), 0);
        start_msg(2'd1, "t6b");
        send_byte(8'hFA, 1'b1);
        wait_done(20, k);
        check("t6_done_latency", 32'(k), 4);

        tick();
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_select_ctrl.md
Name: dec_select_ctrl

Overview:
Sequencing controller for the decryption datapath. It accepts algorithm-select requests and owns the 2-bit select that steers the demux and output mux. It gates the ciphertext stream into the decryptors one message at a time. It never changes select mid-message: it switches only after the active decryptor has drained.

Parameters:
D_WIDTH, 8, data byte width
END_TOKEN, 8'hFA, end-of-message byte; it is forwarded to the decryptor, then the message closes
QUIET_CYC, 4, consecutive idle cycles required in DRAIN before release (legal range 1..15)
TIMEOUT, 255, maximum DRAIN cycles before an error abort (legal range 1..255)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
sel_req_i  in  2  requested algorithm: 0, 1 or 2; 3 is illegal
sel_req_valid_i  in  1  request strobe
sel_req_ready_o  out  1  request slot empty
data_i  in  D_WIDTH  ciphertext byte
valid_i  in  1  byte valid
ready_o  out  1  controller accepts byte
dec_data_o  out  D_WIDTH  byte to the demux
dec_valid_o  out  1  byte valid to the demux
select_o  out  2  select for the demux and the output mux
busy_i  in  3  per-decryptor busy, bit k = decryptor k
out_valid_i  in  1  valid_o of the output mux
done_o  out  1  one-cycle pulse: message fully drained
err_o  out  1  one-cycle pulse: illegal request or drain timeout

Behaviour:
- Reset values: all outputs 0, except sel_req_ready_o=1. Internally: state=IDLE, pending slot empty, counters 0.
- Request slot:
  - One entry deep. A request is accepted when sel_req_valid_i && sel_req_ready_o && sel_req_i != 3.
  - sel_req_i==3 with valid high: request dropped, err_o pulses the next cycle, slot unchanged.
  - sel_req_ready_o = slot empty (registered).
- State IDLE:
  - ready_o=0.
  - If the slot is full: select_o <= slot value, slot cleared, go to ARM.
- State ARM:
  - One settle cycle with ready_o=0.
  - Next state is RUN. ready_o=1 from the first RUN cycle.
- State RUN:
  - ready_o=1. A byte is accepted on valid_i && ready_o.
  - Accepted byte at cycle N appears as dec_data_o/dec_valid_o at N+1. dec_valid_o is otherwise 0 and dec_data_o holds its value.
  - An accepted byte equal to END_TOKEN: forwarded, next state DRAIN, ready_o=0 from the next cycle.
- State DRAIN:
  - ready_o=0.
  - quiet counter increments when busy_i[select_o]==0 and out_valid_i==0, else clears.
  - Counter reaches QUIET_CYC: done_o pulses, go to IDLE.
  - DRAIN cycle counter reaches TIMEOUT first: err_o pulses, go to IDLE. Timeout wins if both occur in the same cycle.
- select_o changes only on the IDLE->ARM transition. It holds through ARM, RUN and DRAIN, and holds in IDLE.
- A request may be accepted in any state, including the same cycle the slot is consumed. Consume and refill in one cycle are allowed, so sel_req_ready_o is effectively 1 in IDLE.
- A back-to-back message starts at the earliest: DRAIN exit -> IDLE -> ARM -> RUN, i.e. 2 cycles after done_o.
- Synchronous reset mid-message: everything returns to reset values in one cycle. The in-flight byte is dropped and select_o returns to 0.
- busy_i bits of non-selected decryptors are ignored.

Decomposition:
- Shared package dec_pkg: state enum (IDLE, ARM, RUN, DRAIN), the legal select constants SEL_0/SEL_1/SEL_2, and END_TOKEN default.
- One natural sub-module: dec_drain_monitor, containing the quiet counter and timeout counter. Outputs: drain_ok, drain_timeout.

Test Plan:
1. Request sel=1, stream 0x41,0x42,0xFA with valid held, no busy -> select_o=1 two cycles after the request; dec_data_o 0x41,0x42,0xFA on consecutive cycles; done_o 4 cycles after the last dec_valid_o.
2. Request sel=2 while the sel=0 message is in RUN -> select_o stays 0 until done_o; it becomes 2 one cycle after done_o, with ready_o=1 the cycle after.
3. Request sel=3 -> err_o pulses once, sel_req_ready_o stays 1, select_o unchanged, no state change.
4. In DRAIN, hold busy_i[select_o]=1 for 300 cycles -> err_o at DRAIN cycle 255, state IDLE, done_o never asserted.
5. In DRAIN, toggle out_valid_i every 3 cycles for 20 cycles, then idle -> quiet counter restarts each time; done_o exactly 4 idle cycles after the last toggle.
6. rst_n low for 1 cycle mid-RUN after byte 0x55 -> all outputs at reset values on the next cycle; 0x55 is not re-emitted; a fresh sel=1 request is then accepted normally.
